// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: two-requester round-robin front end for the single-port
// Data_Memory. Each transaction takes three cycles (IDLE sample, ACCESS with a
// single memory strobe, RESP with the done pulse). Port 0 is the load/store
// unit, port 1 the debug/loader.
module data_memory_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Write_Data,
  output logic              Mem_Write,
  output logic              Mem_Read,
  input  logic [DATA_W-1:0] Read_Data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   last_grant;  // port that won most recently; 1 after reset so port 0 wins first tie
  logic   port;        // port of the transaction in flight
  logic   we_q;
  logic   misalign;
  logic   win;

  // Winner selection: a lone requester wins, a tie goes to the port not granted last
  always_comb begin
    win = (req0 && req1) ? ~last_grant : ~req0;
  end

  // Memory strobes are decoded from state and gated by reset so a reset in ACCESS kills the write
  always_comb begin
    Mem_Write = 1'b0;
    Mem_Read  = 1'b0;
    if (state == ACCESS && !misalign && !reset) begin
      Mem_Write = we_q;
      Mem_Read  = ~we_q;
    end
  end

  // Sequencer: latch winner in IDLE, access memory in ACCESS, report in RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      port       <= 1'b0;
      we_q       <= 1'b0;
      misalign   <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      busy       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      Mem_Addr   <= '0;
      Write_Data <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            port       <= win;
            we_q       <= win ? we1 : we0;
            Mem_Addr   <= win ? addr1 : addr0;
            Write_Data <= win ? wdata1 : wdata0;
            misalign   <= win ? |addr1[2:0] : |addr0[2:0];
            gnt0       <= ~win;
            gnt1       <= win;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!misalign && !we_q) begin
            if (port) rdata1 <= Read_Data;
            else      rdata0 <= Read_Data;
          end
          last_grant <= port;
          done0      <= ~port;
          done1      <= port;
          err0       <= ~port & misalign;
          err1       <= port & misalign;
          state      <= RESP;
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed vector table, hand sequences for
// contention/reset/idle, then random traffic against a transaction-level model.
module tb_data_memory_arbiter;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } op_t;

  typedef struct {
    bit          a0;
    bit          a1;
    op_t         o0;
    op_t         o1;
    int          e_first;
    logic [63:0] e_rd0;
    logic [63:0] e_rd1;
    bit          e_err0;
    bit          e_err1;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1, busy;
  logic [63:0] rdata0, rdata1, Mem_Addr, Write_Data, Read_Data;
  logic        Mem_Write, Mem_Read;

  int total = 0;
  int bad   = 0;

  // stand-in Data_Memory: 32 doublewords
  logic [63:0] mem [0:31];
  assign Read_Data = mem[Mem_Addr[7:3]];
  always @(posedge clk) if (Mem_Write) mem[Mem_Addr[7:3]] <= Write_Data;

  // reference model state
  logic [63:0] ref_mem [0:31];
  logic [63:0] m_rd [0:1];
  int          m_last;

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1), .busy(busy),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
    .Mem_Write(Mem_Write), .Mem_Read(Mem_Read), .Read_Data(Read_Data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: serve the tied/lone requests in round-robin order against a flat memory
  task automatic model_apply(input int p, input op_t o, output bit e);
    e = |o.addr[2:0];
    if (!e) begin
      if (o.we) ref_mem[o.addr[7:3]] = o.wdata;
      else      m_rd[p] = ref_mem[o.addr[7:3]];
    end
    m_last = p;
  endtask

  task automatic model(input bit a0, input bit a1, input op_t o0, input op_t o1,
                       output int first, output bit e0, output bit e1);
    e0 = 0; e1 = 0;
    first = (a0 && a1) ? (m_last == 1 ? 0 : 1) : (a0 ? 0 : 1);
    if (first == 0) begin
      if (a0) model_apply(0, o0, e0);
      if (a1) model_apply(1, o1, e1);
    end else begin
      if (a1) model_apply(1, o1, e1);
      if (a0) model_apply(0, o0, e0);
    end
  endtask

  // Issue up to one request per port at once and check the whole exchange
  task automatic txn2(input bit a0, input bit a1, input op_t o0, input op_t o1,
                      input int e_first, input logic [63:0] e_rd0, input logic [63:0] e_rd1,
                      input bit e_err0, input bit e_err1);
    int cyc = 0, nd = 0, npend, first = -1, gfc = -1, gc0 = -1, gc1 = -1, mw = 0, mr = 0;
    int emw = 0, emr = 0;
    npend = int'(a0) + int'(a1);
    if (a0 && |o0.addr[2:0] == 1'b0) begin if (o0.we) emw++; else emr++; end
    if (a1 && |o1.addr[2:0] == 1'b0) begin if (o1.we) emw++; else emr++; end
    req0 = a0; we0 = o0.we; addr0 = o0.addr; wdata0 = o0.wdata;
    req1 = a1; we1 = o1.we; addr1 = o1.addr; wdata1 = o1.wdata;
    while (nd < npend && cyc < 16) begin
      @(negedge clk);
      cyc++;
      if (Mem_Write) mw++;
      if (Mem_Read)  mr++;
      if (gnt0) begin
        chk("gnt0_req", {63'b0, gnt0}, {63'b0, a0});
        gc0 = cyc; if (first < 0) begin first = 0; gfc = cyc; end
        chk("addr0", Mem_Addr, o0.addr);
        if (o0.we) chk("wdata0", Write_Data, o0.wdata);
      end
      if (gnt1) begin
        chk("gnt1_req", {63'b0, gnt1}, {63'b0, a1});
        gc1 = cyc; if (first < 0) begin first = 1; gfc = cyc; end
        chk("addr1", Mem_Addr, o1.addr);
        if (o1.we) chk("wdata1", Write_Data, o1.wdata);
      end
      if (done0) begin
        nd++; req0 = 0;
        chk("lat0", cyc, gc0 + 1);
        chk("err0", {63'b0, err0}, {63'b0, e_err0});
      end
      if (done1) begin
        nd++; req1 = 0;
        chk("lat1", cyc, gc1 + 1);
        chk("err1", {63'b0, err1}, {63'b0, e_err1});
      end
    end
    req0 = 0; req1 = 0;
    if (nd < npend) chk("timeout", nd, npend);
    if (npend > 0) begin
      chk("order", first, e_first);
      chk("gnt_cyc", gfc, 1);
    end
    chk("rdata0", rdata0, e_rd0);
    chk("rdata1", rdata1, e_rd1);
    @(negedge clk);
    chk("busy_after", {63'b0, busy}, 64'd0);
    chk("mw_count", mw, emw);
    chk("mr_count", mr, emr);
  endtask

  function automatic op_t mk(input logic we, input logic [63:0] a, input logic [63:0] d);
    op_t o;
    o.we = we; o.addr = a; o.wdata = d;
    return o;
  endfunction

  vec_t vt [9];

  initial begin
    op_t nop, o0, o1;
    int  f;
    bit  e0, e1;
    nop = mk(0, 0, 0);
    for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    m_rd[0] = 0; m_rd[1] = 0; m_last = 1;
    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_outs", {gnt0, gnt1, done0, done1, err0, err1, busy, Mem_Write, Mem_Read},
        9'd0);
    chk("rst_rdata", rdata0 | rdata1 | Mem_Addr | Write_Data, 64'd0);
    reset = 0;

    // contention from reset, both held: grants 0,1,0,1 every third cycle
    req0 = 1; we0 = 0; addr0 = 0;
    req1 = 1; we1 = 0; addr1 = 8;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("cont_gnt0_%0d", c), {63'b0, gnt0},
          {63'b0, (c % 3 == 1) && ((c / 3) % 2 == 0)});
      chk($sformatf("cont_gnt1_%0d", c), {63'b0, gnt1},
          {63'b0, (c % 3 == 1) && ((c / 3) % 2 == 1)});
      chk($sformatf("cont_done0_%0d", c), {63'b0, done0},
          {63'b0, (c % 3 == 2) && ((c / 3) % 2 == 0)});
      chk($sformatf("cont_done1_%0d", c), {63'b0, done1},
          {63'b0, (c % 3 == 2) && ((c / 3) % 2 == 1)});
      if (c == 11) begin req0 = 0; req1 = 0; end
    end
    m_last = 1;

    // directed table
    vt[0] = '{1, 0, mk(1, 0, 10), nop,     0, 0, 0, 0, 0};
    vt[1] = '{1, 0, mk(0, 0, 0), nop,      0, 10, 0, 0, 0};
    vt[2] = '{0, 1, nop, mk(1, 8, 4),      1, 10, 0, 0, 0};
    vt[3] = '{1, 0, mk(0, 8, 0), nop,      0, 4, 0, 0, 0};
    vt[4] = '{1, 0, mk(0, 0, 0), nop,      0, 10, 0, 0, 0};
    vt[5] = '{0, 1, nop, mk(1, 4, 99),     1, 10, 0, 0, 1};
    vt[6] = '{1, 0, mk(0, 0, 0), nop,      0, 10, 0, 0, 0};
    vt[7] = '{1, 1, mk(0, 8, 0), mk(0, 0, 0), 1, 4, 10, 0, 0};
    vt[8] = '{1, 1, mk(1, 24, 7), mk(0, 24, 0), 1, 4, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      model(vt[i].a0, vt[i].a1, vt[i].o0, vt[i].o1, f, e0, e1);
      txn2(vt[i].a0, vt[i].a1, vt[i].o0, vt[i].o1, vt[i].e_first,
           vt[i].e_rd0, vt[i].e_rd1, vt[i].e_err0, vt[i].e_err1);
    end
    chk("mem8_backdoor", mem[1], 64'd4);

    // reset during ACCESS of a write of 55 to address 16
    req0 = 1; we0 = 1; addr0 = 16; wdata0 = 55;
    @(negedge clk);
    chk("rstacc_gnt0", {63'b0, gnt0}, 64'd1);
    chk("rstacc_mw_pre", {63'b0, Mem_Write}, 64'd1);
    reset = 1;
    #1;
    chk("rstacc_mw", {63'b0, Mem_Write}, 64'd0);
    req0 = 0;
    @(negedge clk);
    chk("rstacc_outs", {gnt0, gnt1, done0, done1, err0, err1, busy, Mem_Write, Mem_Read},
        9'd0);
    chk("rstacc_regs", rdata0 | rdata1 | Mem_Addr | Write_Data, 64'd0);
    reset = 0;
    m_last = 1; m_rd[0] = 0; m_rd[1] = 0;
    model(1, 0, mk(0, 16, 0), nop, f, e0, e1);
    txn2(1, 0, mk(0, 16, 0), nop, 0, 0, 0, 0, 0);

    // idle: nothing moves for 20 cycles
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle", {59'b0, busy, Mem_Write, Mem_Read, gnt0 | gnt1, done0 | done1}, 64'd0);
    end

    // random traffic against the model
    for (int it = 0; it < 40; it++) begin
      bit ra0, ra1;
      ra0 = 1'($urandom_range(0, 1));
      ra1 = 1'($urandom_range(0, 1));
      if (!ra0 && !ra1) ra1 = 1;
      o0 = mk(1'($urandom_range(0, 1)), {56'b0, 5'($urandom_range(0, 31)), 3'b0},
              {$urandom, $urandom});
      o1 = mk(1'($urandom_range(0, 1)), {56'b0, 5'($urandom_range(0, 31)), 3'b0},
              {$urandom, $urandom});
      if ($urandom_range(0, 5) == 0) o0.addr[2:0] = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 5) == 0) o1.addr[2:0] = 3'($urandom_range(1, 7));
      model(ra0, ra1, o0, o1, f, e0, e1);
      txn2(ra0, ra1, o0, o1, f, m_rd[0], m_rd[1], e0, e1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
